// File: rtl/seven_seg_scan_if.sv
// Display bus between the core logic (master) and the seven-segment scanner (slave).
// Carries the values to show plus the board-facing segment/anode pins and the frame strobe.
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] in_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic [NUM_DIGITS-1:0]   blank_i;
  logic                    lz_en_i;
  logic [3:0]              bright_i;
  logic [7:0]              seg_o;
  logic [NUM_DIGITS-1:0]   an_o;
  logic                    frame_o;

  modport master (
    output in_i, dp_i, blank_i, lz_en_i, bright_i,
    input  seg_o, an_o, frame_o
  );

  modport slave (
    input  in_i, dp_i, blank_i, lz_en_i, bright_i,
    output seg_o, an_o, frame_o
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with per-frame input latching,
// decimal points, leading-zero blanking, force-blank mask and 16-level PWM brightness.
module seven_seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_CNT    = 50000
) (
  input  logic            clk,
  input  logic            reset,
  seven_seg_scan_if.slave bus
);
  localparam int STEP  = DIV_CNT / 16;
  localparam int CNT_W = $clog2(DIV_CNT);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW    = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW-1:0]         in_s_q;
  logic [NUM_DIGITS-1:0] dp_s_q, blank_s_q;
  logic                  lz_s_q;
  logic [3:0]            bright_s_q;
  logic                  load_pending_q;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_q;

  logic                  tick, load;
  logic [DW-1:0]         in_e;
  logic [NUM_DIGITS-1:0] dp_e, blank_e, zero_from;
  logic                  lz_e;
  logic [3:0]            bright_e, nib;
  logic                  dark, pwm_on, lit;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    load  = load_pending_q | (tick & (idx_q == IDX_LAST));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // The very first slot after reset is displayed from the values being latched right now,
  // so the panel never flashes the all-zero shadow contents.
  always_comb begin
    in_e     = load_pending_q ? bus.in_i     : in_s_q;
    dp_e     = load_pending_q ? bus.dp_i     : dp_s_q;
    blank_e  = load_pending_q ? bus.blank_i  : blank_s_q;
    lz_e     = load_pending_q ? bus.lz_en_i  : lz_s_q;
    bright_e = load_pending_q ? bus.bright_i : bright_s_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zero_from[k] = ((in_e >> (4 * k)) == '0);
    end
  end

  always_comb begin
    nib    = in_e[4*idx_q +: 4];
    dark   = blank_e[idx_q] | (lz_e & (idx_q != '0) & zero_from[idx_q]);
    pwm_on = int'(cnt_q) < (int'(bright_e) + 1) * STEP;
    lit    = pwm_on & ~dark;
    seg_d  = 8'hFF;
    an_d   = '1;
    if (lit) begin
      seg_d = {~dp_e[idx_q], decode(nib)};
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      in_s_q         <= '0;
      dp_s_q         <= '0;
      blank_s_q      <= '0;
      lz_s_q         <= 1'b0;
      bright_s_q     <= '0;
      load_pending_q <= 1'b1;
      seg_q          <= 8'hFF;
      an_q           <= '1;
      frame_q        <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
      frame_q        <= load;
      load_pending_q <= 1'b0;
      if (load) begin
        in_s_q     <= bus.in_i;
        dp_s_q     <= bus.dp_i;
        blank_s_q  <= bus.blank_i;
        lz_s_q     <= bus.lz_en_i;
        bright_s_q <= bus.bright_i;
      end
    end
  end

  assign bus.seg_o   = seg_q;
  assign bus.an_o    = an_q;
  assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: a position-based reference model predicts every
// output cycle, and directed literal checks pin the model to known display patterns.
module tb_seven_seg_scan;
  localparam int NUM_DIGITS = 4;
  localparam int DIV_CNT    = 16;
  localparam int STEP       = DIV_CNT / 16;
  localparam int FRAME_LEN  = NUM_DIGITS * DIV_CNT;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   nCompared   = 0;
  int   nMismatched = 0;

  seven_seg_scan_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

  seven_seg_scan #(.NUM_DIGITS(NUM_DIGITS), .DIV_CNT(DIV_CNT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Segment patterns (g..a, active-low) for hex digits 0..F.
  logic [6:0] decodeTbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [15:0] mIn;
  logic [3:0]  mDp, mBlank, mBright;
  logic        mLz;
  int          pos = 0;
  bit          modelValid = 0;
  logic [7:0]  expSeg;
  logic [3:0]  expAn;
  logic        expFrame;

  task automatic latchInputs();
    mIn     = bus.in_i;
    mDp     = bus.dp_i;
    mBlank  = bus.blank_i;
    mLz     = bus.lz_en_i;
    mBright = bus.bright_i;
  endtask

  // Position p counts clocks since reset release; slot and digit follow by division.
  task automatic predict(input int p);
    int  cnt, d;
    bit  dark, on;
    cnt  = p % DIV_CNT;
    d    = (p / DIV_CNT) % NUM_DIGITS;
    dark = mBlank[d] || (mLz && d > 0 && ((mIn >> (4 * d)) == 16'h0));
    on   = cnt < (int'(mBright) + 1) * STEP;
    if (dark || !on) begin
      expSeg = 8'hFF;
      expAn  = 4'hF;
    end else begin
      expSeg = {~mDp[d], decodeTbl[(mIn >> (4 * d)) & 16'hF]};
      expAn  = ~(4'b0001 << d);
    end
  endtask

  // Reference model: frame k uses inputs latched at the start (p=0) or at the last cycle of frame k-1.
  always @(posedge clk) begin
    if (!reset) begin
      expSeg     = 8'hFF;
      expAn      = 4'hF;
      expFrame   = 1'b0;
      pos        = 0;
      modelValid = 1;
    end else if (modelValid) begin
      if (pos == 0) latchInputs();
      predict(pos);
      expFrame = (pos == 0) || (pos % FRAME_LEN == FRAME_LEN - 1);
      if (pos % FRAME_LEN == FRAME_LEN - 1) latchInputs();
      pos++;
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      nCompared++;
      if (bus.seg_o !== expSeg || bus.an_o !== expAn || bus.frame_o !== expFrame) begin
        nMismatched++;
        $display("[TB] FAIL model t=%0t pos=%0d: got seg=%h an=%h frame=%b, expected seg=%h an=%h frame=%b",
                 $time, pos, bus.seg_o, bus.an_o, bus.frame_o, expSeg, expAn, expFrame);
      end
      nCompared++;
      if ($countones(~bus.an_o) > 1) begin
        nMismatched++;
        $display("[TB] FAIL onehot t=%0t: an=%b has more than one anode low", $time, bus.an_o);
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                               input logic l, input logic [3:0] br);
    bus.in_i     = v;
    bus.dp_i     = d;
    bus.blank_i  = b;
    bus.lz_en_i  = l;
    bus.bright_i = br;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic waitFrame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_o !== 1'b1 && n < 2 * FRAME_LEN + 4);
    if (bus.frame_o !== 1'b1) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL frameTimeout: got frame=%b, expected a pulse within %0d cycles", bus.frame_o, n);
    end
  endtask

  initial begin
    int litCount, seg80Count;
    applyStimulus(16'h5555, 4'h0, 4'h0, 1'b0, 4'hF);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetSeg", 32'(bus.seg_o), 32'hFF);
    checkOutput("resetAn", 32'(bus.an_o), 32'hF);
    checkOutput("resetFrame", 32'(bus.frame_o), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("firstFrame", 32'(bus.frame_o), 32'h1);
    checkOutput("firstAn", 32'(bus.an_o), 32'hE);
    checkOutput("firstSeg", 32'(bus.seg_o), 32'h92);
    repeat (16) @(negedge clk);
    checkOutput("scanAnD", 32'(bus.an_o), 32'hD);
    repeat (16) @(negedge clk);
    checkOutput("scanAnB", 32'(bus.an_o), 32'hB);
    repeat (16) @(negedge clk);
    checkOutput("scanAn7", 32'(bus.an_o), 32'h7);
    repeat (16) @(negedge clk);
    checkOutput("scanWrapAnE", 32'(bus.an_o), 32'hE);

    applyStimulus(16'h00A0, 4'b0010, 4'h0, 1'b1, 4'hF);
    waitFrame();
    @(negedge clk);
    checkOutput("lzDigit0Seg", 32'(bus.seg_o), 32'hC0);
    repeat (16) @(negedge clk);
    checkOutput("lzDigit1Seg", 32'(bus.seg_o), 32'h08);
    checkOutput("lzDigit1An", 32'(bus.an_o), 32'hD);
    applyStimulus(16'h1234, 4'b0010, 4'h0, 1'b1, 4'hF);
    repeat (16) @(negedge clk);
    checkOutput("midFrameDigit2Dark", 32'({bus.an_o, bus.seg_o}), 32'hFFF);
    waitFrame();
    @(negedge clk);
    checkOutput("newDigit0Seg", 32'(bus.seg_o), 32'h99);
    repeat (48) @(negedge clk);
    checkOutput("newDigit3Seg", 32'(bus.seg_o), 32'hF9);
    checkOutput("newDigit3An", 32'(bus.an_o), 32'h7);

    applyStimulus(16'h5555, 4'h0, 4'h0, 1'b0, 4'd3);
    waitFrame();
    litCount = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.an_o == 4'hE) litCount++;
    end
    checkOutput("pwmBright3", 32'(litCount), 32'd4);
    applyStimulus(16'h5555, 4'h0, 4'h0, 1'b0, 4'd0);
    waitFrame();
    litCount = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.an_o == 4'hE) litCount++;
    end
    checkOutput("pwmBright0", 32'(litCount), 32'd1);

    applyStimulus(16'h8888, 4'h0, 4'b0100, 1'b0, 4'hF);
    waitFrame();
    litCount   = 0;
    seg80Count = 0;
    repeat (FRAME_LEN) begin
      @(negedge clk);
      if (bus.an_o[2] == 1'b0) litCount++;
      if (bus.seg_o == 8'h80) seg80Count++;
    end
    checkOutput("blankDigit2Lit", 32'(litCount), 32'd0);
    checkOutput("blankSeg80Cycles", 32'(seg80Count), 32'd48);

    applyStimulus(16'h5555, 4'h0, 4'h0, 1'b0, 4'hF);
    waitFrame();
    repeat (33) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midResetSegAn", 32'({bus.an_o, bus.seg_o}), 32'hFFF);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("restartFrame", 32'(bus.frame_o), 32'h1);
    checkOutput("restartAn", 32'(bus.an_o), 32'hE);

    // Randomised traffic: sporadic input changes (often mid-frame) and rare resets.
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) begin
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 1) == 0) v = v >> (4 * $urandom_range(1, 4));
        applyStimulus(v, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                      1'($urandom), 4'($urandom));
      end
      if ($urandom_range(0, 699) == 0) begin
        reset = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        reset = 1'b1;
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
